// File: rtl/p251_pkg.sv
// p251_pkg: shared GF(251) constants for the multiply-reduce datapath and its arbiter.
package p251_pkg;
    localparam logic [7:0] P251 = 8'd251;
    localparam int P251_W = 8;
    localparam int PROD_W = 16;
    localparam int P251_RED_LAT = 2;
endpackage

// File: rtl/p251_mul_red.sv
// p251_mul_red: two-cycle reduction of a 16-bit product mod 251; one issue per cycle, no reset.
module p251_mul_red
    import p251_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_start,
    input  logic [PROD_W-1:0] i_a,
    output logic [P251_W-1:0] o_c,
    output logic              o_done
);
    // 256 = 5 mod 251: fold the high byte twice, then one conditional subtract suffices
    logic [10:0] fold1;
    logic [8:0]  fold2;
    logic        done1;

    always_comb fold2 = 9'(fold1[10:8]) * 9'd5 + 9'(fold1[7:0]);

    always_ff @(posedge i_clk) begin
        fold1  <= 11'(i_a[15:8]) * 11'd5 + 11'(i_a[7:0]);
        done1  <= i_start;
        o_c    <= fold2 >= 9'(P251) ? 8'(fold2 - 9'(P251)) : fold2[7:0];
        o_done <= done1;
    end
endmodule

// File: rtl/p251_mul_arb.sv
// p251_mul_arb: round-robin sharing of one p251_mul_red among NUM_REQ requesters,
// with a tag pipeline steering each reduced result back to its issuer.
module p251_mul_arb
    import p251_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int RED_LAT = P251_RED_LAT
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [NUM_REQ*8-1:0] i_a,
    input  logic [NUM_REQ*8-1:0] i_b,
    output logic [NUM_REQ-1:0]   o_gnt,
    output logic [7:0]           o_c,
    output logic [NUM_REQ-1:0]   o_valid,
    output logic                 o_busy
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int TW   = RED_LAT * ID_W;

    logic [ID_W-1:0]   rr, gid, k_idx, id0, head_id;
    logic [PROD_W-1:0] prod;
    logic              v0, xfer, head_v, red_done;
    logic [RED_LAT-1:0] tag_v;
    logic [TW-1:0]     tag_id;
    logic [P251_W-1:0] red_c;

    // walk from the farthest offset down so the nearest requester above rr wins
    always_comb begin
        o_gnt = '0;
        gid   = '0;
        k_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k_idx = ID_W'((int'(rr) + i) % NUM_REQ);
            if (i_req[k_idx]) begin
                o_gnt = NUM_REQ'(1) << k_idx;
                gid   = k_idx;
            end
        end
    end

    assign xfer    = |o_gnt;
    assign head_v  = tag_v[RED_LAT-1];
    assign head_id = tag_id[TW-1 -: ID_W];
    assign o_busy  = v0 | |tag_v | |o_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr      <= '0;
            v0      <= 1'b0;
            id0     <= '0;
            prod    <= '0;
            tag_v   <= '0;
            tag_id  <= '0;
            o_valid <= '0;
            o_c     <= '0;
        end else begin
            v0 <= xfer;
            if (xfer) begin
                rr   <= gid == ID_W'(NUM_REQ - 1) ? '0 : gid + 1'b1;
                id0  <= gid;
                prod <= PROD_W'(i_a[gid*8 +: 8]) * PROD_W'(i_b[gid*8 +: 8]);
            end
            tag_v   <= RED_LAT'({tag_v, v0});
            tag_id  <= TW'({tag_id, id0});
            o_valid <= head_v ? NUM_REQ'(1) << head_id : '0;
            if (head_v) o_c <= red_c;
        end
    end

    p251_mul_red u_red (
        .i_clk  (i_clk),
        .i_start(v0),
        .i_a    (prod),
        .o_c    (red_c),
        .o_done (red_done)
    );

    // a live tag at the head must line up with the reducer's done strobe
    a_head_done: assert property (@(posedge i_clk) disable iff (!i_rst_n) head_v |-> red_done);
endmodule

// File: tb/tb_p251_mul_arb.sv
// tb_p251_mul_arb: directed + random scoreboard bench; grants push expected results,
// a negedge monitor pops and compares whenever o_valid is raised.
module tb_p251_mul_arb;
    localparam int N   = 4;
    localparam int RL  = 2;
    localparam int LAT = 2 + RL;

    typedef struct {
        int id;
        int c;
        int t;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*8-1:0] a = '0;
    logic [N*8-1:0] b = '0;
    logic [N-1:0]   gnt, valid;
    logic [7:0]     c;
    logic           busy;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   n_ops = 0;
    int   rr_m = 0;
    int   exp_c[N];
    int   wait_c[N];
    int   eg;
    exp_t q[$];
    exp_t e;

    p251_mul_arb #(.NUM_REQ(N), .RED_LAT(RL)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_req  (req),
        .i_a    (a),
        .i_b    (b),
        .o_gnt  (gnt),
        .o_c    (c),
        .o_valid(valid),
        .o_busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard: reference arbiter pushes on grant, outputs are popped in order
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            rr_m = 0;
            for (int k = 0; k < N; k++) wait_c[k] = 0;
        end else begin
            eg = 0;
            for (int i = N - 1; i >= 0; i--)
                if (req[(rr_m + i) % N]) eg = 1 << ((rr_m + i) % N);
            check("gnt", int'(gnt), eg);
            for (int k = 0; k < N; k++) begin
                if (eg[k]) begin
                    q.push_back('{id: k, c: exp_c[k], t: cyc});
                    n_ops++;
                    rr_m = (k + 1) % N;
                    checks++;
                    if (wait_c[k] > N - 1) begin
                        errors++;
                        $display("FAIL grant_wait req%0d: waited %0d, limit %0d", k, wait_c[k], N - 1);
                    end
                    wait_c[k] = 0;
                end else if (req[k]) begin
                    wait_c[k]++;
                end
            end
            if (valid != 0) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got o_valid=%b o_c=%0d, expected none", valid, c);
                end else begin
                    e = q.pop_front();
                    check("result_c", int'(c), e.c);
                    check("result_valid", int'(valid), 1 << e.id);
                    check("latency", cyc - e.t, LAT);
                end
            end
        end
    end

    task automatic issue(input int k, input int av, input int bv, input int ec, input bit hold);
        bit got;
        got = 1'b0;
        a[k*8 +: 8] = 8'(av);
        b[k*8 +: 8] = 8'(bv);
        exp_c[k] = ec;
        req[k] = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = gnt[k];
        end
        check("grant_seen", int'(got), 1);
        @(posedge clk);
        #1;
        if (!hold) req[k] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (q.size() != 0 || busy); i++) @(negedge clk);
        check("drain_queue", q.size(), 0);
        check("drain_busy", int'(busy), 0);
    endtask

    task automatic quiet(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            check("quiet_busy", int'(busy), 0);
            check("quiet_valid", int'(valid), 0);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        req = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] g;
        int av, bv;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        quiet(20);

        issue(0, 251, 1, 0, 1'b0);
        drain();

        issue(0, 250, 250, 1, 1'b1);
        issue(0, 200, 100, 171, 1'b1);
        issue(0, 255, 255, 16, 1'b0);
        drain();

        // rotation from a fresh pointer: grants 0,1,2,3,0,1
        pulse_reset();
        exp_c = '{1, 8, 15, 22};
        for (int k = 0; k < N; k++) begin
            a[k*8 +: 8] = 8'd7;
            b[k*8 +: 8] = 8'(36 + k);
        end
        req = '1;
        repeat (6) @(posedge clk);
        #1;
        req = '0;
        drain();

        // three ops in flight are killed by reset
        req = '1;
        repeat (3) @(posedge clk);
        #1;
        pulse_reset();
        quiet(10);

        for (int i = 0; n_ops < 10000 && i < 40000; i++) begin
            @(negedge clk);
            g = gnt & req;
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (!req[k] || g[k]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        av = $urandom_range(0, 255);
                        bv = $urandom_range(0, 255);
                        a[k*8 +: 8] = 8'(av);
                        b[k*8 +: 8] = 8'(bv);
                        exp_c[k] = (av * bv) % 251;
                        req[k] = 1'b1;
                    end else begin
                        req[k] = 1'b0;
                    end
                end
            end
        end
        req = '0;
        check("random_ops_done", int'(n_ops >= 10000), 1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
